// File: rtl/img_capture_sequencer.sv
// Capture/readout sequencer for the image controller's toggle-command interface.
// Takes one host request at a time: issues the capture toggle, waits for the
// capture-done toggle and checks the pixel count (retrying on mismatch), then
// issues the readout toggle and counts streamed words up to the expected total.
// Finishes with a one-cycle response pulse that carries status and capture stats.
module img_capture_sequencer #(
  parameter int unsigned ExpectedPixelCount = 2304 * 1296,
  parameter int unsigned FullWordCount      = 2304 * 1296 + 32,
  parameter int unsigned ThumbWordCount     = 576 * 324 + 32,
  parameter int unsigned MaxRetries         = 2,
  parameter int unsigned TimeoutCycles      = 1_080_000,
  parameter int unsigned CountWidth         = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_thumb,
  input  logic                  req_ramBlock,
  input  logic                  req_skipCount,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [CountWidth-1:0] resp_pixelCount,
  output logic [17:0]           resp_highlightCount,
  output logic [17:0]           resp_shadowCount,
  output logic [1:0]            resp_retries,
  output logic                  cmd_capture,
  output logic                  cmd_readout,
  output logic                  cmd_ramBlock,
  output logic                  cmd_skipCount,
  output logic                  cmd_thumb,
  input  logic                  status_captureDone,
  input  logic [CountWidth-1:0] status_capturePixelCount,
  input  logic [17:0]           status_captureHighlightCount,
  input  logic [17:0]           status_captureShadowCount,
  input  logic                  readout_ready,
  input  logic                  readout_trigger
);

  // The timer never passes TimeoutCycles-1, so clog2 bits always hold it.
  localparam int TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerWidth-1:0] TimerLast      = TimerWidth'(TimeoutCycles - 1);
  localparam logic [CountWidth-1:0] ExpectedPixels = CountWidth'(ExpectedPixelCount);
  localparam logic [CountWidth-1:0] FullWords      = CountWidth'(FullWordCount);
  localparam logic [CountWidth-1:0] ThumbWords     = CountWidth'(ThumbWordCount);
  localparam logic [1:0]            RetryLimit     = 2'(MaxRetries);

  localparam logic [1:0] StatusOk         = 2'd0;
  localparam logic [1:0] StatusCapTimeout = 2'd1;
  localparam logic [1:0] StatusPixelBad   = 2'd2;
  localparam logic [1:0] StatusRdTimeout  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, CAP_ISSUE, CAP_WAIT, CHECK, RD_ISSUE, RD_WAIT, RESP
  } state_t;

  state_t                  state, state_next;
  logic                    done_snap;
  logic [TimerWidth-1:0]   timer;
  logic [CountWidth-1:0]   word_count;
  logic [CountWidth-1:0]   word_target;
  logic [CountWidth-1:0]   word_inc;
  logic [1:0]              retries;
  logic                    accept;
  logic                    done_edge;
  logic                    xfer;
  logic                    timer_expired;
  logic                    pixel_ok;
  logic                    last_word;

  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);
  assign resp_retries  = retries;
  assign accept        = req_valid && req_ready;
  // Only inequality against the snapshot matters, so the controller's toggle
  // phase at request time is irrelevant.
  assign done_edge     = (status_captureDone != done_snap);
  assign xfer          = readout_ready && readout_trigger;
  assign timer_expired = (timer == TimerLast);
  assign pixel_ok      = (resp_pixelCount == ExpectedPixels);
  // Saturating increment: the word counter sticks at all-ones instead of wrapping.
  assign word_inc      = (word_count == '1) ? word_count : word_count + CountWidth'(1);
  assign last_word     = xfer && (word_inc == word_target);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    // NOTE: defaulting first means no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = CAP_ISSUE;
      CAP_ISSUE: state_next = CAP_WAIT;
      // A done edge on the timeout cycle still counts as a completed capture.
      CAP_WAIT: begin
        if (done_edge)          state_next = CHECK;
        else if (timer_expired) state_next = RESP;
      end
      CHECK: begin
        if (pixel_ok)                 state_next = RD_ISSUE;
        else if (retries < RetryLimit) state_next = CAP_ISSUE;
        else                          state_next = RESP;
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (xfer) begin
          if (last_word) state_next = RESP;
        end else if (timer_expired) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command toggles, latched request fields, timers, counters and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_capture         <= 1'b0;
      cmd_readout         <= 1'b0;
      cmd_ramBlock        <= 1'b0;
      cmd_skipCount       <= 1'b0;
      cmd_thumb           <= 1'b0;
      done_snap           <= 1'b0;
      timer               <= '0;
      word_count          <= '0;
      word_target         <= '0;
      retries             <= '0;
      resp_status         <= StatusOk;
      resp_pixelCount     <= '0;
      resp_highlightCount <= '0;
      resp_shadowCount    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_thumb     <= req_thumb;
            cmd_ramBlock  <= req_ramBlock;
            cmd_skipCount <= req_skipCount;
            retries       <= '0;
            resp_status   <= StatusOk;
          end
        end
        CAP_ISSUE: begin
          cmd_capture <= ~cmd_capture;
          done_snap   <= status_captureDone;
          timer       <= '0;
        end
        CAP_WAIT: begin
          if (done_edge) begin
            resp_pixelCount     <= status_capturePixelCount;
            resp_highlightCount <= status_captureHighlightCount;
            resp_shadowCount    <= status_captureShadowCount;
          end else if (timer_expired) begin
            resp_status <= StatusCapTimeout;
          end else begin
            timer <= timer + TimerWidth'(1);
          end
        end
        CHECK: begin
          if (!pixel_ok) begin
            if (retries < RetryLimit) retries <= retries + 2'd1;
            else                      resp_status <= StatusPixelBad;
          end
        end
        RD_ISSUE: begin
          cmd_readout <= ~cmd_readout;
          word_count  <= '0;
          timer       <= '0;
          word_target <= cmd_thumb ? ThumbWords : FullWords;
        end
        RD_WAIT: begin
          if (xfer) begin
            word_count <= word_inc;
            timer      <= '0;
            if (last_word) resp_status <= StatusOk;
          end else if (timer_expired) begin
            resp_status <= StatusRdTimeout;
          end else begin
            timer <= timer + TimerWidth'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_capture_sequencer.sv
// Directed bench for img_capture_sequencer with a response scoreboard.
// Expected responses are queued when a request is issued; a negedge monitor
// pops and compares them whenever resp_valid is seen, and counts command toggles.
module tb_img_capture_sequencer;

  localparam int unsigned Cw = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_thumb, req_ramBlock, req_skipCount;
  logic          resp_valid;
  logic [1:0]    resp_status, resp_retries;
  logic [Cw-1:0] resp_pixelCount;
  logic [17:0]   resp_highlightCount, resp_shadowCount;
  logic          cmd_capture, cmd_readout, cmd_ramBlock, cmd_skipCount, cmd_thumb;
  logic          status_captureDone;
  logic [Cw-1:0] status_capturePixelCount;
  logic [17:0]   status_captureHighlightCount, status_captureShadowCount;
  logic          readout_ready, readout_trigger;

  img_capture_sequencer #(
    .ExpectedPixelCount(16),
    .FullWordCount     (40),
    .ThumbWordCount    (12),
    .MaxRetries        (2),
    .TimeoutCycles     (100),
    .CountWidth        (Cw)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .req_valid                   (req_valid),
    .req_ready                   (req_ready),
    .req_thumb                   (req_thumb),
    .req_ramBlock                (req_ramBlock),
    .req_skipCount               (req_skipCount),
    .resp_valid                  (resp_valid),
    .resp_status                 (resp_status),
    .resp_pixelCount             (resp_pixelCount),
    .resp_highlightCount         (resp_highlightCount),
    .resp_shadowCount            (resp_shadowCount),
    .resp_retries                (resp_retries),
    .cmd_capture                 (cmd_capture),
    .cmd_readout                 (cmd_readout),
    .cmd_ramBlock                (cmd_ramBlock),
    .cmd_skipCount               (cmd_skipCount),
    .cmd_thumb                   (cmd_thumb),
    .status_captureDone          (status_captureDone),
    .status_capturePixelCount    (status_capturePixelCount),
    .status_captureHighlightCount(status_captureHighlightCount),
    .status_captureShadowCount   (status_captureShadowCount),
    .readout_ready               (readout_ready),
    .readout_trigger             (readout_trigger)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    status;
    logic [1:0]    retries;
    logic [Cw-1:0] pix;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            failures = 0;
  int            resp_seen = 0;
  int            resp_pushed = 0;
  int            cap_flips = 0;
  int            rd_flips = 0;
  int            base_c, base_r;
  logic          cap_prev = 1'b0;
  logic          rd_prev = 1'b0;
  logic          cap_seen = 1'b0;
  logic          rd_seen = 1'b0;
  logic [Cw-1:0] last_pix = '0;

  function automatic logic [17:0] hl_of(input logic [Cw-1:0] p);
    return 18'(p * 3 + 1);
  endfunction

  function automatic logic [17:0] sh_of(input logic [Cw-1:0] p);
    return 18'(p + 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: toggle counting and scoreboard comparison on each response pulse.
  always @(negedge clk) begin
    if (cmd_capture !== cap_prev) cap_flips++;
    if (cmd_readout !== rd_prev)  rd_flips++;
    cap_prev = cmd_capture;
    rd_prev  = cmd_readout;
    if (resp_valid === 1'b1) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_status",    32'(resp_status),         32'(mon_e.status));
        check("resp_retries",   32'(resp_retries),        32'(mon_e.retries));
        check("resp_pixel",     32'(resp_pixelCount),     32'(mon_e.pix));
        check("resp_highlight", 32'(resp_highlightCount), 32'(hl_of(mon_e.pix)));
        check("resp_shadow",    32'(resp_shadowCount),    32'(sh_of(mon_e.pix)));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [1:0] rt, input logic [Cw-1:0] px);
    exp_t e;
    e.status = st; e.retries = rt; e.pix = px;
    exp_q.push_back(e);
    resp_pushed++;
  endtask

  task automatic send_req(input logic thumb, input logic ram, input logic skip);
    int k = 0;
    req_valid = 1'b1; req_thumb = thumb; req_ramBlock = ram; req_skipCount = skip;
    while (req_ready !== 1'b1 && k < 500) begin cyc(1); k++; end
    check("req_ready_wait", 32'(req_ready), 1);
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_cap_flip(input int budget);
    int k = 0;
    while (cmd_capture === cap_seen && k < budget) begin cyc(1); k++; end
    check("cap_flip_seen", 32'(cmd_capture !== cap_seen), 1);
    cap_seen = cmd_capture;
  endtask

  task automatic wait_rd_flip(input int budget);
    int k = 0;
    while (cmd_readout === rd_seen && k < budget) begin cyc(1); k++; end
    check("rd_flip_seen", 32'(cmd_readout !== rd_seen), 1);
    rd_seen = cmd_readout;
  endtask

  task automatic report(input logic [Cw-1:0] count);
    status_capturePixelCount     = count;
    status_captureHighlightCount = hl_of(count);
    status_captureShadowCount    = sh_of(count);
    status_captureDone           = ~status_captureDone;
    last_pix                     = count;
  endtask

  task automatic do_capture(input logic [Cw-1:0] count, input int delay);
    wait_cap_flip(200);
    cyc(delay);
    report(count);
  endtask

  // Streams n transfers, inserting one ready-only and one trigger-only cycle.
  task automatic stream(input int n);
    logic early = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 2) begin
        readout_ready = 1'b1; readout_trigger = 1'b0;
        cyc(1);
        readout_ready = 1'b0; readout_trigger = 1'b1;
        cyc(1);
      end
      readout_ready = 1'b1; readout_trigger = 1'b1;
      @(negedge clk);
      if (resp_valid !== 1'b0) early = 1'b1;
      cyc(1);
    end
    readout_ready = 1'b0; readout_trigger = 1'b0;
    check("no_resp_during_stream", 32'(early), 0);
  endtask

  // Expects resp_valid low for n cycles from now, then high on cycle n.
  task automatic expect_resp_at(input int n, input string tag);
    logic early = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) early = 1'b1;
    end
    @(negedge clk);
    check({tag, "_early"}, 32'(early), 0);
    check(tag, 32'(resp_valid), 1);
    cyc(1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin cyc(1); k++; end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_thumb = 1'b0; req_ramBlock = 1'b0; req_skipCount = 1'b0;
    status_captureDone = 1'b0; status_capturePixelCount = '0;
    status_captureHighlightCount = '0; status_captureShadowCount = '0;
    readout_ready = 1'b0; readout_trigger = 1'b0;
    cyc(2);
    @(negedge clk);
    check("rst_req_ready",   32'(req_ready), 1);
    check("rst_resp_valid",  32'(resp_valid), 0);
    check("rst_cmd_capture", 32'(cmd_capture), 0);
    check("rst_cmd_readout", 32'(cmd_readout), 0);
    check("rst_resp_status", 32'(resp_status), 0);
    check("rst_resp_pixel",  32'(resp_pixelCount), 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Nominal full readout, with accept-to-toggle latency.
    base_c = cap_flips; base_r = rd_flips;
    push_exp(2'd0, 2'd0, 16);
    send_req(1'b0, 1'b1, 1'b1);
    check("nom_cmd_ramBlock",  32'(cmd_ramBlock), 1);
    check("nom_cmd_skipCount", 32'(cmd_skipCount), 1);
    check("nom_cmd_thumb",     32'(cmd_thumb), 0);
    check("nom_cap_not_yet",   32'(cmd_capture), 32'(cap_seen));
    cyc(1);
    check("nom_cap_latency",   32'(cmd_capture), 32'(!cap_seen));
    do_capture(16, 20);
    wait_rd_flip(20);
    stream(40);
    expect_resp_at(0, "nom_resp");
    check("nom_cap_flips", cap_flips - base_c, 1);
    check("nom_rd_flips",  rd_flips - base_r, 1);

    // Two mismatches, then a good count.
    base_c = cap_flips; base_r = rd_flips;
    push_exp(2'd0, 2'd2, 16);
    send_req(1'b0, 1'b0, 1'b0);
    do_capture(15, 5);
    do_capture(15, 5);
    do_capture(16, 5);
    wait_rd_flip(20);
    stream(40);
    expect_resp_at(0, "retry_resp");
    check("retry_cap_flips", cap_flips - base_c, 3);
    check("retry_rd_flips",  rd_flips - base_r, 1);

    // Retries exhausted.
    base_c = cap_flips; base_r = rd_flips;
    push_exp(2'd2, 2'd2, 15);
    send_req(1'b0, 1'b0, 1'b0);
    do_capture(15, 3);
    do_capture(15, 3);
    do_capture(15, 3);
    wait_drain();
    check("exhaust_cap_flips", cap_flips - base_c, 3);
    check("exhaust_rd_flips",  rd_flips - base_r, 0);

    // Capture timeout: stats keep the last reported values.
    base_r = rd_flips;
    push_exp(2'd1, 2'd0, last_pix);
    send_req(1'b0, 1'b0, 1'b0);
    wait_cap_flip(20);
    expect_resp_at(100, "cap_timeout_resp");
    check("cap_timeout_rd_flips", rd_flips - base_r, 0);

    // Done toggle on the timeout cycle still proceeds.
    push_exp(2'd0, 2'd0, 16);
    send_req(1'b0, 1'b0, 1'b0);
    wait_cap_flip(20);
    cyc(99);
    report(16);
    wait_rd_flip(20);
    stream(40);
    expect_resp_at(0, "late_done_resp");

    // Readout stall, with a thumbnail request held pending while busy.
    push_exp(2'd3, 2'd0, 16);
    send_req(1'b0, 1'b1, 1'b0);
    do_capture(16, 4);
    wait_rd_flip(20);
    stream(5);
    req_valid = 1'b1; req_thumb = 1'b1; req_ramBlock = 1'b0; req_skipCount = 1'b1;
    push_exp(2'd0, 2'd0, 16);
    base_c = cap_flips;
    expect_resp_at(100, "stall_resp");
    check("busy_not_accepted_thumb", 32'(cmd_thumb), 0);
    check("busy_no_cap_flip",        cap_flips - base_c, 0);
    check("b2b_req_ready",           32'(req_ready), 1);
    cyc(1);
    req_valid = 1'b0;
    check("b2b_cmd_thumb",     32'(cmd_thumb), 1);
    check("b2b_cmd_skipCount", 32'(cmd_skipCount), 1);
    check("b2b_cmd_ramBlock",  32'(cmd_ramBlock), 0);
    do_capture(16, 20);
    wait_rd_flip(20);
    stream(12);
    expect_resp_at(0, "thumb_resp");

    // Reset in RD_WAIT aborts silently; controller reset alongside.
    send_req(1'b0, 1'b0, 1'b0);
    do_capture(16, 3);
    wait_rd_flip(20);
    stream(3);
    rst = 1'b1; status_captureDone = 1'b0; cap_seen = 1'b0; rd_seen = 1'b0;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_req_ready",   32'(req_ready), 1);
    check("mid_rst_cmd_capture", 32'(cmd_capture), 0);
    check("mid_rst_cmd_readout", 32'(cmd_readout), 0);
    check("mid_rst_resp_valid",  32'(resp_valid), 0);
    cyc(3);
    push_exp(2'd0, 2'd0, 16);
    send_req(1'b0, 1'b1, 1'b1);
    do_capture(16, 10);
    wait_rd_flip(20);
    stream(40);
    expect_resp_at(0, "post_rst_resp");

    wait_drain();
    check("resp_count", resp_seen, resp_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
